sel_mux_pipe: RTL and testbench
===============================

Name: sel_mux_pipe

Overview:
- Parametrised N-way, WIDTH-bit operand selector for the datapath. Generalises the fixed 3-input 32-bit select.
- Adds a registered output stage with a valid/ready handshake and a 2-entry skid buffer, so a select point can sit between pipeline stages at full throughput.
- Optionally flags out-of-range select codes.

Parameters:
- WIDTH, 32, data width of each input and the output.
- NUM_IN, 3, number of selectable inputs (2..16).
- SEL_W, 2, select width; must satisfy 2^SEL_W >= NUM_IN.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  NUM_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- in_sel  input  SEL_W  select code for the current transfer.
- in_valid  input  1  upstream has a transfer.
- in_ready  output  1  block can accept a transfer; registered.
- out_data  output  WIDTH  selected word.
- out_sel  output  SEL_W  select code that produced out_data.
- out_valid  output  1  out_data/out_sel are valid.
- out_ready  input  1  downstream accepts the output.
- err_clr  input  1  clears err (optional feature only).
- err  output  1  sticky out-of-range flag (optional feature only).

Behaviour:
- Transfers:
  - An input transfer occurs when in_valid && in_ready at a rising clk edge.
  - An output transfer occurs when out_valid && out_ready at a rising clk edge.
- Selection:
  - Word = input[in_sel] if in_sel < NUM_IN.
  - Otherwise input 0 (out-of-range codes map to input 0).
  - Word and raw in_sel are captured together; out_sel reports the raw code.
- Storage:
  - Main register (drives out_*) plus one skid register.
  - States: EMPTY (out_valid=0), ONE (main full, skid empty), FULL (both full).
- Transitions:
  - EMPTY: input transfer -> ONE, main loads.
  - ONE, input and output transfer -> ONE, main reloads.
  - ONE, input only -> FULL, skid loads.
  - ONE, output only -> EMPTY.
  - ONE, neither -> ONE.
  - FULL, out_ready -> ONE, main <= skid, skid emptied.
  - FULL, !out_ready -> FULL.
  - No input is accepted in FULL.
- Handshake signals:
  - in_ready = registered (next_state != FULL). Upstream therefore sees ready drop the cycle after the skid fills.
  - The skid absorbs the in-flight word.
- Timing:
  - Latency: 1 cycle from an input transfer to out_valid, when empty.
  - Throughput: 1 transfer/cycle while out_ready=1.
- Stability: while out_valid && !out_ready, out_data and out_sel hold stable.
- Ordering: strictly FIFO; no reordering and no drop while in_ready is honoured.
- Reset:
  - State EMPTY, out_valid=0, out_data=0, out_sel=0, in_ready=1, err=0, skid cleared.
  - Any handshake in a cycle with reset=1 is ignored.
  - Reset mid-operation discards buffered words.
- in_data and in_sel are sampled only on an input transfer; their values at other times are don't-care.

Optional Feature:
- Macro: SEL_MUX_PIPE_ERR_EN.
- Defined:
  - err sets on an input transfer with in_sel >= NUM_IN. The data path still routes input 0.
  - err stays set until err_clr=1 or reset.
  - If a set and a clear land in the same cycle, set wins.
- Undefined:
  - err is tied to 0 and err_clr is ignored.
  - No error logic is synthesised; datapath behaviour is identical.

Test Plan:
- Default params, reset, inputs {A=0x11111111, B=0x22222222, C=0x33333333}, send sel=0,1,2 back-to-back with out_ready=1:
  - out_data is 0x11111111, 0x22222222, 0x33333333 on consecutive cycles, starting 1 cycle after the first transfer.
  - in_ready stays 1.
- sel=3 with default params:
  - out_data=input 0, out_sel=3.
  - With SEL_MUX_PIPE_ERR_EN, err=1 next cycle and stays 1 until err_clr.
  - Without the macro, err stays 0.
- Backpressure:
  - Hold out_ready=0 and stream 3 words D0..D2: D0 in main, D1 in skid, in_ready=0, D2 held upstream.
  - Raise out_ready: outputs D0, D1, D2 in order, none lost or duplicated.
- Reset asserted while FULL:
  - The next cycle shows out_valid=0, in_ready=1, out_data=0.
  - The next transfer emerges normally.
- WIDTH=8, NUM_IN=5, SEL_W=3, random in_valid/out_ready for 1000 cycles:
  - Output sequence matches a reference-model FIFO of selected words.
  - Codes 5..7 map to input 0.
- Simultaneous err_clr=1 and an out-of-range transfer (macro on): err remains 1.

Source files
------------

// File: rtl/sel_mux_pipe.sv
// N-way WIDTH-bit operand selector with a registered valid/ready output stage and a 2-entry skid.
// Define SEL_MUX_PIPE_ERR_EN to add a sticky flag for out-of-range select codes.
module sel_mux_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned NUM_IN = 3,
    parameter int unsigned SEL_W  = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    input  logic                    err_clr,
    output logic                    err
);

    typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic [SEL_W-1:0] main_sel_q, main_sel_d;
    logic [SEL_W-1:0] skid_sel_q, skid_sel_d;
    logic             in_ready_q;
    logic             in_xfer;
    logic [WIDTH-1:0] sel_word;

    // Codes at or above NUM_IN fall through to input 0.
    always_comb begin
        sel_word = in_data[WIDTH-1:0];
        for (int unsigned k = 1; k < NUM_IN; k++) begin
            if (in_sel == SEL_W'(k)) begin
                sel_word = in_data[k*WIDTH +: WIDTH];
            end
        end
    end

    assign in_xfer = in_valid & in_ready_q;

    always_comb begin
        state_d     = state_q;
        main_data_d = main_data_q;
        main_sel_d  = main_sel_q;
        skid_data_d = skid_data_q;
        skid_sel_d  = skid_sel_q;
        unique case (state_q)
            StEmpty: begin
                if (in_xfer) begin
                    state_d     = StOne;
                    main_data_d = sel_word;
                    main_sel_d  = in_sel;
                end
            end
            StOne: begin
                if (in_xfer && out_ready) begin
                    main_data_d = sel_word;
                    main_sel_d  = in_sel;
                end else if (in_xfer) begin
                    state_d     = StFull;
                    skid_data_d = sel_word;
                    skid_sel_d  = in_sel;
                end else if (out_ready) begin
                    state_d = StEmpty;
                end
            end
            StFull: begin
                // in_ready is low here, so only the drain path applies.
                if (out_ready) begin
                    state_d     = StOne;
                    main_data_d = skid_data_q;
                    main_sel_d  = skid_sel_q;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StEmpty;
            main_data_q <= '0;
            main_sel_q  <= '0;
            skid_data_q <= '0;
            skid_sel_q  <= '0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            main_data_q <= main_data_d;
            main_sel_q  <= main_sel_d;
            skid_data_q <= skid_data_d;
            skid_sel_q  <= skid_sel_d;
            in_ready_q  <= (state_d != StFull);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q != StEmpty);
    assign out_data  = main_data_q;
    assign out_sel   = main_sel_q;

`ifdef SEL_MUX_PIPE_ERR_EN
    logic err_q;
    logic sel_oor;

    assign sel_oor = (32'(in_sel) >= NUM_IN);

    // A new out-of-range transfer takes priority over a clear in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else if (in_xfer && sel_oor) begin
            err_q <= 1'b1;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end
    end

    assign err = err_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign err            = 1'b0;
`endif

endmodule

// File: tb/tb_sel_mux_pipe.sv
// Bench for sel_mux_pipe: directed checks on the default build plus a randomized
// run on an 8-bit, 5-input instance compared against a FIFO reference model.
module tb_sel_mux_pipe;

`ifdef SEL_MUX_PIPE_ERR_EN
    localparam logic ERR_ON = 1'b1;
`else
    localparam logic ERR_ON = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [95:0] a_in_data;
    logic [1:0]  a_in_sel;
    logic        a_in_valid, a_in_ready;
    logic [31:0] a_out_data;
    logic [1:0]  a_out_sel;
    logic        a_out_valid, a_out_ready, a_err_clr, a_err;

    logic [39:0] b_in_data;
    logic [2:0]  b_in_sel;
    logic        b_in_valid, b_in_ready;
    logic [7:0]  b_out_data;
    logic [2:0]  b_out_sel;
    logic        b_out_valid, b_out_ready, b_err_clr, b_err;

    sel_mux_pipe u_dut_a (
        .clk      (clk),
        .reset    (reset),
        .in_data  (a_in_data),
        .in_sel   (a_in_sel),
        .in_valid (a_in_valid),
        .in_ready (a_in_ready),
        .out_data (a_out_data),
        .out_sel  (a_out_sel),
        .out_valid(a_out_valid),
        .out_ready(a_out_ready),
        .err_clr  (a_err_clr),
        .err      (a_err)
    );

    sel_mux_pipe #(.WIDTH(8), .NUM_IN(5), .SEL_W(3)) u_dut_b (
        .clk      (clk),
        .reset    (reset),
        .in_data  (b_in_data),
        .in_sel   (b_in_sel),
        .in_valid (b_in_valid),
        .in_ready (b_in_ready),
        .out_data (b_out_data),
        .out_sel  (b_out_sel),
        .out_valid(b_out_valid),
        .out_ready(b_out_ready),
        .err_clr  (b_err_clr),
        .err      (b_err)
    );

    int n_assert = 0;
    int n_fail   = 0;

    logic [10:0] q[$];  // {sel, word} pending at the output of u_dut_b
    logic        err_exp;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int          sz;
        int unsigned eff;
        logic [7:0]  word;

        reset       = 1'b1;
        a_in_data   = '0;
        a_in_sel    = '0;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b0;
        a_err_clr   = 1'b0;
        b_in_data   = '0;
        b_in_sel    = '0;
        b_in_valid  = 1'b0;
        b_out_ready = 1'b0;
        b_err_clr   = 1'b0;
        err_exp     = 1'b0;
        cyc();
        cyc();
        reset = 1'b0;

        chk("rst_out_valid", a_out_valid, 0);
        chk("rst_out_data", a_out_data, 0);
        chk("rst_out_sel", a_out_sel, 0);
        chk("rst_in_ready", a_in_ready, 1);
        chk("rst_err", a_err, 0);
        chk("rst_b_out_valid", b_out_valid, 0);
        chk("rst_b_in_ready", b_in_ready, 1);

        // Back-to-back selects 0,1,2 at full throughput.
        a_in_data   = {32'h33333333, 32'h22222222, 32'h11111111};
        a_out_ready = 1'b1;
        a_in_valid  = 1'b1;
        a_in_sel    = 2'd0;
        cyc();
        chk("b2b0_valid", a_out_valid, 1);
        chk("b2b0_data", a_out_data, 32'h11111111);
        chk("b2b0_ready", a_in_ready, 1);
        a_in_sel = 2'd1;
        cyc();
        chk("b2b1_data", a_out_data, 32'h22222222);
        chk("b2b1_ready", a_in_ready, 1);
        a_in_sel = 2'd2;
        cyc();
        chk("b2b2_data", a_out_data, 32'h33333333);
        chk("b2b2_sel", a_out_sel, 2);
        chk("b2b2_ready", a_in_ready, 1);
        a_in_valid = 1'b0;
        cyc();
        chk("b2b_drained", a_out_valid, 0);

        // Out-of-range code routes input 0 and drives the sticky flag.
        a_in_valid = 1'b1;
        a_in_sel   = 2'd3;
        cyc();
        chk("oor_data", a_out_data, 32'h11111111);
        chk("oor_sel", a_out_sel, 3);
        chk("oor_err", a_err, ERR_ON);
        a_in_valid = 1'b0;
        cyc();
        chk("oor_err_sticky", a_err, ERR_ON);
        a_err_clr = 1'b1;
        cyc();
        chk("oor_err_clr", a_err, 0);
        a_in_valid = 1'b1;
        cyc();
        chk("oor_set_wins", a_err, ERR_ON);
        a_in_valid = 1'b0;
        cyc();
        chk("oor_err_clr2", a_err, 0);
        a_err_clr = 1'b0;
        cyc();

        // Backpressure: D0 in main, D1 in skid, D2 waits upstream.
        a_out_ready     = 1'b0;
        a_in_sel        = 2'd0;
        a_in_valid      = 1'b1;
        a_in_data[31:0] = 32'hD0D0D0D0;
        cyc();
        chk("bp_d0", a_out_data, 32'hD0D0D0D0);
        chk("bp_ready1", a_in_ready, 1);
        a_in_data[31:0] = 32'hD1D1D1D1;
        cyc();
        chk("bp_hold_d0", a_out_data, 32'hD0D0D0D0);
        chk("bp_ready0", a_in_ready, 0);
        a_in_data[31:0] = 32'hD2D2D2D2;
        cyc();
        chk("bp_stable", a_out_data, 32'hD0D0D0D0);
        chk("bp_still_full", a_in_ready, 0);
        chk("bp_valid", a_out_valid, 1);
        a_out_ready = 1'b1;
        cyc();
        chk("bp_d1", a_out_data, 32'hD1D1D1D1);
        chk("bp_ready_back", a_in_ready, 1);
        cyc();
        chk("bp_d2", a_out_data, 32'hD2D2D2D2);
        chk("bp_d2_valid", a_out_valid, 1);
        a_in_valid = 1'b0;
        cyc();
        chk("bp_drained", a_out_valid, 0);

        // Reset while FULL discards both words; a handshake during reset is ignored.
        a_out_ready      = 1'b0;
        a_in_valid       = 1'b1;
        a_in_sel         = 2'd1;
        a_in_data[63:32] = 32'hCAFEF00D;
        cyc();
        cyc();
        chk("full_before_rst", a_in_ready, 0);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("rstf_valid", a_out_valid, 0);
        chk("rstf_ready", a_in_ready, 1);
        chk("rstf_data", a_out_data, 0);
        a_in_sel        = 2'd0;
        a_in_data[31:0] = 32'h5A5A5A5A;
        a_out_ready     = 1'b1;
        cyc();
        chk("rstf_next_valid", a_out_valid, 1);
        chk("rstf_next_data", a_out_data, 32'h5A5A5A5A);
        a_in_valid = 1'b0;
        cyc();
        chk("rstf_next_drained", a_out_valid, 0);

        // Randomized traffic on the 8-bit, 5-input instance.
        for (int i = 0; i < 1000; i++) begin
            chk("rnd_in_ready", b_in_ready, (q.size() < 2));
            chk("rnd_out_valid", b_out_valid, (q.size() > 0));
            if (q.size() > 0) begin
                chk("rnd_out_data", b_out_data, q[0][7:0]);
                chk("rnd_out_sel", b_out_sel, q[0][10:8]);
            end
            chk("rnd_err", b_err, err_exp);

            b_in_valid  = 1'($urandom_range(0, 1));
            b_out_ready = 1'($urandom_range(0, 1));
            b_in_sel    = 3'($urandom_range(0, 7));
            b_in_data   = 40'({$urandom(), $urandom()});

            sz = q.size();
            if (sz > 0 && b_out_ready) begin
                void'(q.pop_front());
            end
            if (b_in_valid && sz < 2) begin
                eff  = (b_in_sel < 3'd5) ? 32'(b_in_sel) : 0;
                word = 8'(b_in_data >> (8 * eff));
                q.push_back({b_in_sel, word});
                if (b_in_sel >= 3'd5) begin
                    err_exp = ERR_ON;
                end
            end
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
